// File: rtl/softmax_out_serializer_if.sv
// Handshake bundle between the softmax vector producer/stream consumer and softmax_out_serializer.
// The almost_full flag is present only when SER_ALMOST_FULL_EN is defined.
interface softmax_out_serializer_if #(
   parameter int N      = 8,
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  en;
   logic                  valid_in;
   logic [N*DATA_W-1:0]   in_flat;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_data;
   logic [IDX_W-1:0]      out_idx;
   logic                  out_last;
   logic [CNT_W-1:0]      count;
   logic                  overflow;
`ifdef SER_ALMOST_FULL_EN
   logic                  almost_full;

   modport master (
      output en, valid_in, in_flat, out_ready,
      input  out_valid, out_data, out_idx, out_last, count, overflow, almost_full
   );
   modport slave (
      input  en, valid_in, in_flat, out_ready,
      output out_valid, out_data, out_idx, out_last, count, overflow, almost_full
   );
`else
   modport master (
      output en, valid_in, in_flat, out_ready,
      input  out_valid, out_data, out_idx, out_last, count, overflow
   );
   modport slave (
      input  en, valid_in, in_flat, out_ready,
      output out_valid, out_data, out_idx, out_last, count, overflow
   );
`endif
endinterface

// File: rtl/softmax_out_serializer.sv
// Buffers whole softmax vectors in a DEPTH-entry FIFO and replays them one element per cycle.
// Optional almost_full output is enabled by defining SER_ALMOST_FULL_EN.
module softmax_out_serializer #(
   parameter int N      = 8,
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   softmax_out_serializer_if.slave bus
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

   logic [N*DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [IDX_W-1:0]    elem_idx_q, elem_idx_d;
   logic                overflow_q, overflow_d;

   logic                out_valid;
   logic                pop_elem;
   logic                pop_vec;
   logic                push_ok;
   logic                drop;
   logic [N*DATA_W-1:0] head_vec;

   always_comb begin
      out_valid  = (count_q != '0);
      pop_elem   = bus.en & out_valid & bus.out_ready;
      pop_vec    = pop_elem & (elem_idx_q == LAST_IDX);
      // A full FIFO still accepts when the head vector retires in the same cycle
      push_ok    = bus.en & bus.valid_in & ((count_q < DEPTH_C) | pop_vec);
      drop       = bus.en & bus.valid_in & ~push_ok;

      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      elem_idx_d = elem_idx_q;
      overflow_d = overflow_q | drop;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_elem) begin
         if (pop_vec) begin
            elem_idx_d = '0;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         end else begin
            elem_idx_d = elem_idx_q + IDX_W'(1);
         end
      end
      case ({push_ok, pop_vec})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         elem_idx_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         elem_idx_q <= elem_idx_d;
         overflow_q <= overflow_d;
      end
   end

   // Vector storage carries no reset; only the pointers define what is live
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= bus.in_flat;
      end
   end

   always_comb begin
      head_vec      = mem_q[rd_ptr_q];
      bus.out_valid = out_valid;
      bus.out_data  = out_valid ? head_vec[elem_idx_q*DATA_W +: DATA_W] : '0;
      bus.out_idx   = elem_idx_q;
      bus.out_last  = out_valid & (elem_idx_q == LAST_IDX);
      bus.count     = count_q;
      bus.overflow  = overflow_q;
   end

`ifdef SER_ALMOST_FULL_EN
   assign bus.almost_full = (count_q >= (DEPTH_C - CNT_W'(1)));
`endif

endmodule

// File: tb/tb_softmax_out_serializer.sv
// Self-checking bench for softmax_out_serializer: directed table, corner sequences, random run
// against a queue-based reference model. Honors SER_ALMOST_FULL_EN when defined.
module tb_softmax_out_serializer;
   localparam int N     = 8;
   localparam int DEPTH = 4;
   localparam int VW    = N * 16;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   softmax_out_serializer_if #(.N(N), .DEPTH(DEPTH), .DATA_W(16)) bus ();

   softmax_out_serializer #(.N(N), .DEPTH(DEPTH), .DATA_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of whole vectors plus the read position in the head vector
   logic [VW-1:0] mq[$];
   int            midx = 0;
   bit            movf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      bit pe, pv, full;
      if (rst) begin
         mq.delete();
         midx = 0;
         movf = 1'b0;
      end else if (bus.en) begin
         full = (mq.size() >= DEPTH);
         pe   = (mq.size() != 0) && bus.out_ready;
         pv   = pe && (midx == N - 1);
         if (pe) begin
            if (pv) begin
               midx = 0;
               void'(mq.pop_front());
            end else begin
               midx++;
            end
         end
         if (bus.valid_in) begin
            if (!full || pv) mq.push_back(bus.in_flat);
            else movf = 1'b1;
         end
      end
   endtask

   task automatic model_check();
      logic [VW-1:0] hv;
      logic [15:0]   ed;
      bit            ev;
      ev = (mq.size() != 0);
      ed = 16'h0000;
      if (ev) begin
         hv = mq[0];
         ed = hv[midx*16 +: 16];
      end
      check("m_valid", 32'(bus.out_valid), 32'(ev));
      check("m_data",  32'(bus.out_data),  32'(ed));
      check("m_idx",   32'(bus.out_idx),   32'(midx));
      check("m_last",  32'(bus.out_last),  32'(ev && midx == N - 1));
      check("m_count", 32'(bus.count),     32'(mq.size()));
      check("m_ovf",   32'(bus.overflow),  32'(movf));
`ifdef SER_ALMOST_FULL_EN
      check("m_afull", 32'(bus.almost_full), 32'(mq.size() >= DEPTH - 1));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      model_check();
   endtask

   function automatic logic [VW-1:0] make_vec(input logic [15:0] base);
      logic [VW-1:0] v;
      for (int i = 0; i < N; i++) v[i*16 +: 16] = base + 16'(i);
      return v;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < N; i++) v[i*16 +: 16] = 16'($urandom);
      return v;
   endfunction

   task automatic push_vec(input logic [VW-1:0] v);
      bus.valid_in = 1'b1;
      bus.in_flat  = v;
      step();
      bus.valid_in = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        rst, en, vld, rdy;
      logic [VW-1:0] vec;
      logic        e_valid;
      logic [15:0] e_data;
      int          e_idx;
      logic        e_last;
      int          e_cnt;
      logic        e_ovf;
   } row_t;

   row_t tbl[11];

   initial begin
      logic [15:0] bases[4];
      int          p;
      bit          r;

      // Directed single-vector drain with hand-derived expectations
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, '0, 1'b0, 16'h0000, 0, 1'b0, 0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, make_vec(16'h0100), 1'b1, 16'h0100, 0, 1'b0, 1, 1'b0};
      for (int k = 2; k <= 8; k++)
         tbl[k] = '{1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b1, 16'h0100 + 16'(k - 1), k - 1, (k == 8), 1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0, 16'h0000, 0, 1'b0, 0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0, 16'h0000, 0, 1'b0, 0, 1'b0};

      rst = 1'b1;
      bus.en = 1'b1;
      bus.valid_in = 1'b0;
      bus.in_flat = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;

      for (int k = 0; k < 11; k++) begin
         rst           = tbl[k].rst;
         bus.en        = tbl[k].en;
         bus.valid_in  = tbl[k].vld;
         bus.out_ready = tbl[k].rdy;
         bus.in_flat   = tbl[k].vec;
         step();
         check("t1_valid", 32'(bus.out_valid), 32'(tbl[k].e_valid));
         check("t1_data",  32'(bus.out_data),  32'(tbl[k].e_data));
         check("t1_idx",   32'(bus.out_idx),   32'(tbl[k].e_idx));
         check("t1_last",  32'(bus.out_last),  32'(tbl[k].e_last));
         check("t1_count", 32'(bus.count),     32'(tbl[k].e_cnt));
         check("t1_ovf",   32'(bus.overflow),  32'(tbl[k].e_ovf));
      end
      bus.valid_in = 1'b0;
      rst = 1'b0;

      // Overflow: fifth vector dropped, first four drain in order
      do_reset();
      bus.out_ready = 1'b0;
      bases = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
      for (int k = 0; k < 4; k++) push_vec(make_vec(bases[k]));
      push_vec(make_vec(16'h5000));
      check("t2_count", 32'(bus.count), 32'd4);
      check("t2_ovf",   32'(bus.overflow), 32'd1);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 32; k++) begin
         check("t2_drain", 32'(bus.out_data), 32'(bases[k/8] + 16'(k % 8)));
         step();
      end
      check("t2_empty", 32'(bus.out_valid), 32'd0);
      check("t2_ovf_sticky", 32'(bus.overflow), 32'd1);

      // Full FIFO with pop_vec and push on the same edge
      do_reset();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) push_vec(make_vec(16'h0A00 + 16'(k) * 16'h0100));
      bus.out_ready = 1'b1;
      for (int k = 0; k < 7; k++) step();
      check("t3_idx7", 32'(bus.out_idx), 32'd7);
      push_vec(make_vec(16'h0F00));
      check("t3_count", 32'(bus.count), 32'd4);
      check("t3_ovf",   32'(bus.overflow), 32'd0);
      check("t3_head",  32'(bus.out_data), 32'h0B00);

      // Ready toggling mid-vector
      do_reset();
      bus.out_ready = 1'b0;
      push_vec(make_vec(16'h0C00));
      p = 0;
      for (int j = 0; j < 12; j++) begin
         r = (j < 8) ? (j % 2 == 0) : 1'b1;
         bus.out_ready = r;
         step();
         p += int'(r);
         if (p < N) begin
            check("t4_idx",  32'(bus.out_idx),  32'(p));
            check("t4_data", 32'(bus.out_data), 32'(16'h0C00 + 16'(p)));
         end
      end
      check("t4_empty", 32'(bus.out_valid), 32'd0);

      // Freeze with en=0 while full and draining
      do_reset();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) push_vec(make_vec(16'h0D00 + 16'(k) * 16'h0100));
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) step();
      bus.en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.valid_in = (k == 2);
         bus.in_flat  = rand_vec();
         step();
         check("t5_idx",   32'(bus.out_idx),  32'd3);
         check("t5_data",  32'(bus.out_data), 32'h0D03);
         check("t5_count", 32'(bus.count),    32'd4);
         check("t5_ovf",   32'(bus.overflow), 32'd0);
      end
      bus.valid_in = 1'b0;
      bus.en = 1'b1;
      step();
      check("t5_resume", 32'(bus.out_idx), 32'd4);

      // Reset mid-vector with two vectors stored; valid_in on the reset edge is dropped
      do_reset();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) push_vec(make_vec(16'h0E00 + 16'(k) * 16'h0100));
      check("t6_count3", 32'(bus.count), 32'd3);
`ifdef SER_ALMOST_FULL_EN
      check("t6_afull1", 32'(bus.almost_full), 32'd1);
`endif
      bus.out_ready = 1'b1;
      for (int k = 0; k < 11; k++) step();
      check("t6_count2", 32'(bus.count), 32'd2);
      check("t6_idx3",   32'(bus.out_idx), 32'd3);
      rst = 1'b1;
      bus.valid_in = 1'b1;
      bus.in_flat = rand_vec();
      step();
      rst = 1'b0;
      bus.valid_in = 1'b0;
      check("t6_valid", 32'(bus.out_valid), 32'd0);
      check("t6_count", 32'(bus.count),     32'd0);
      check("t6_idx",   32'(bus.out_idx),   32'd0);
      check("t6_ovf",   32'(bus.overflow),  32'd0);
`ifdef SER_ALMOST_FULL_EN
      check("t6_afull0", 32'(bus.almost_full), 32'd0);
`endif
      step();
      check("t6_drop", 32'(bus.count), 32'd0);

      // Random traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         rst           = ($urandom_range(0, 199) == 0);
         bus.en        = ($urandom_range(0, 9) != 0);
         bus.valid_in  = ($urandom_range(0, 5) == 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.in_flat   = rand_vec();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
